irq_requester: RTL

- Device-side initiator of the CPU interrupt request/grant handshake.
- Turns three raw board push-buttons into prioritised interrupt requests (code, BK).
- Presents each request to the CPU interrupt unit, holds it until the CPU returns a grant (IG), then retires it.
- Runs on the board clock clk, not the gated pipeline clock, so requests are never lost while the pipeline is stalled.

---
 rtl/irq_requester_pkg.sv | 31 +++
 rtl/irq_requester_btn_debounce.sv | 49 ++++
 rtl/irq_requester.sv | 109 ++++++++++
 3 files changed

// File: rtl/irq_requester_pkg.sv
// Shared encodings for the interrupt requester: request levels, FSM states,
// debounce default and the fixed priority resolution.
package irq_requester_pkg;

    localparam int NSRC             = 3;
    localparam int DEBOUNCE_DEFAULT = 100000;

    typedef enum logic [1:0] {
        LVL_NONE = 2'd0,
        LVL_1    = 2'd1,
        LVL_2    = 2'd2,
        LVL_3    = 2'd3
    } lvl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Highest eligible source wins; bit i of elig is level i+1.
    function automatic lvl_t top_level(input logic [NSRC-1:0] elig);
        lvl_t lvl;
        if (elig[2])      lvl = LVL_3;
        else if (elig[1]) lvl = LVL_2;
        else if (elig[0]) lvl = LVL_1;
        else              lvl = LVL_NONE;
        return lvl;
    endfunction

endpackage

// File: rtl/irq_requester_btn_debounce.sv
// One push-button: 2-flop synchroniser, stability counter and accepted level.
// Emits a single-cycle pulse in the cycle the accepted level becomes 1.
module btn_debounce
    import irq_requester_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync0_reg;
    logic             sync1_reg;
    logic             stable_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_reg  <= 1'b0;
            sync1_reg  <= 1'b0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync0_reg <= btn;
            sync1_reg <= sync0_reg;
            rise_reg  <= 1'b0;
            // Any return to the accepted level restarts the stability count.
            if (sync1_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= sync1_reg;
                rise_reg   <= sync1_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/irq_requester.sv
// Device-side interrupt initiator: debounced buttons become pending levels,
// the highest eligible one is presented as (code, BK) until the CPU grants it.
module irq_requester
    import irq_requester_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       in_RST,
    input  logic [2:0] btn,
    input  logic       IE,
    input  logic [3:0] INM,
    input  logic [3:0] IG,
    output logic [1:0] code,
    output logic       BK,
    output logic [2:0] leds
);

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] pending_reg, pending_next;
    state_t          state_reg, state_next;
    lvl_t            code_reg, code_next;
    logic            bk_reg, bk_next;
    lvl_t            top;
    logic            unused_bits;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            btn_debounce #(
                .DEBOUNCE(DEBOUNCE)
            ) u_debounce (
                .clk  (clk),
                .rst_n(in_RST),
                .btn  (btn[gi]),
                .rise (rise[gi])
            );

            assign eligible[gi] = pending_reg[gi] & ~INM[gi+1] & IE;
        end
    endgenerate

    assign top = top_level(eligible);

    // Grants clear their level regardless of FSM state; a same-cycle rise wins.
    assign pending_next = (pending_reg & ~IG[NSRC:1]) | rise;

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        bk_next    = bk_reg;
        case (state_reg)
            ST_IDLE: begin
                code_next = LVL_NONE;
                bk_next   = 1'b0;
                if (top != LVL_NONE) begin
                    state_next = ST_REQ;
                    code_next  = top;
                    bk_next    = 1'b1;
                end
            end
            ST_REQ: begin
                if (IG[code_reg]) begin
                    state_next = ST_ACK;
                    code_next  = LVL_NONE;
                    bk_next    = 1'b0;
                end else if (top == LVL_NONE) begin
                    state_next = ST_IDLE;
                    code_next  = LVL_NONE;
                    bk_next    = 1'b0;
                end else if (top > code_reg) begin
                    code_next = top;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
                code_next  = LVL_NONE;
                bk_next    = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                code_next  = LVL_NONE;
                bk_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge in_RST) begin
        if (!in_RST) begin
            state_reg   <= ST_IDLE;
            code_reg    <= LVL_NONE;
            bk_reg      <= 1'b0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            bk_reg      <= bk_next;
            pending_reg <= pending_next;
        end
    end

    assign code = code_reg;
    assign BK   = bk_reg;
    assign leds = pending_reg;

    // Level 0 has no source: its mask and grant bits are don't-care.
    assign unused_bits = IG[0] ^ INM[0];

endmodule
